debounce_filter: RTL and testbench



---
 rtl/debounce_filter.sv | 60 ++++++
 tb/tb_debounce_filter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/debounce_filter.sv
// Two-flop synchronizer plus consecutive-sample stability filter for one switch input.
// The output flips only after the synchronized level has differed from it for STABLE_CYCLES clocks.
`timescale 1ns/1ps
module debounce_filter #(
  parameter int CNT_WIDTH     = 7,
  parameter int STABLE_CYCLES = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic out
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 s1_q;
  logic                 s2_q;
  logic                 out_q;
  logic                 out_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= in;
      s2_q <= s1_q;
    end
  end

  // Any sample that agrees with the current output discards the accumulated count.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (s2_q == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      out_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter: reset, clean/bouncy transitions, threshold and reset mid-count.
`timescale 1ns/1ps
module tb_debounce_filter;

  logic clk;
  logic rstn;
  logic in;
  logic out;

  int vectors;
  int errors;

  debounce_filter #(.CNT_WIDTH(7), .STABLE_CYCLES(10)) dut (
    .clk  (clk),
    .rstn (rstn),
    .in   (in),
    .out  (out)
  );

  initial begin
    clk = 1'b0;
    forever #12.5 clk = ~clk;
  end

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input logic exp, input string name);
    vectors++;
    if (out !== exp) begin
      errors++;
      $display("FAIL %s: out=%b expected=%b at %0t", name, out, exp, $time);
    end else begin
      $display("vec %0d %s: out=%b ok", vectors, name, out);
    end
  endtask

  // Caller has just driven in=lvl; edge E0 is the next one. out must hold ~lvl
  // through E0+10 and take lvl at E0+11.
  task automatic check_latency(input logic lvl, input string name);
    for (int k = 0; k < 11; k++) begin
      step();
      check_out(~lvl, $sformatf("%s_hold_e%0d", name, k));
    end
    step();
    check_out(lvl, $sformatf("%s_flip_e11", name));
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    in   = 1'b0;
    #1;
    check_out(1'b0, "reset_immediate");
    for (int k = 0; k < 80; k++) begin
      step();
      if (k % 3 == 0) in = ~in;
      if (k % 8 == 0) check_out(1'b0, "reset_toggle_in");
    end
    in = 1'b0;
    step();
    rstn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k % 5 == 4) check_out(1'b0, "release_in_low");
    end
  endtask

  task automatic test_clean_press();
    in = 1'b1;
    check_latency(1'b1, "clean_press");
    for (int k = 0; k < 3; k++) step();
    check_out(1'b1, "clean_press_held");
    in = 1'b0;
    check_latency(1'b0, "clean_release");
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_bouncy_press();
    for (int b = 0; b < 10; b++) begin
      in = (b % 2 == 0);
      for (int k = 0; k < 4; k++) begin
        step();
        check_out(1'b0, "bouncy_press_bounce");
      end
    end
    in = 1'b1;
    check_latency(1'b1, "bouncy_press");
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_bouncy_release();
    for (int b = 0; b < 10; b++) begin
      in = (b % 2 != 0);
      for (int k = 0; k < 4; k++) begin
        step();
        check_out(1'b1, "bouncy_release_bounce");
      end
    end
    in = 1'b0;
    check_latency(1'b0, "bouncy_release");
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_threshold();
    // Nine clocks high at s2: count peaks at 9 and is discarded.
    in = 1'b1;
    for (int k = 0; k < 9; k++) step();
    in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      check_out(1'b0, "threshold_9_no_flip");
    end
    // Ten clocks high at s2: out flips on E0+11.
    in = 1'b1;
    for (int k = 0; k < 10; k++) step();
    in = 1'b0;
    step();
    check_out(1'b0, "threshold_10_e10");
    step();
    check_out(1'b1, "threshold_10_e11");
    for (int k = 0; k < 15; k++) step();
    check_out(1'b0, "threshold_10_falls_back");
  endtask

  task automatic test_reset_mid_count();
    in = 1'b1;
    check_latency(1'b1, "pre_reset_rise");
    step();
    rstn = 1'b0;
    #2;
    check_out(1'b0, "async_reset_from_high");
    for (int k = 0; k < 3; k++) step();
    check_out(1'b0, "reset_hold_in_high");
    rstn = 1'b1;
    check_latency(1'b1, "post_reset_rise");
    in = 1'b0;
    for (int k = 0; k < 15; k++) step();
    check_out(1'b0, "mid_count_setup_low");
    // After E0..E0+6 the counter holds 5.
    in = 1'b1;
    for (int k = 0; k < 7; k++) step();
    check_out(1'b0, "mid_count_cnt5");
    rstn = 1'b0;
    #2;
    check_out(1'b0, "mid_count_reset_assert");
    step();
    rstn = 1'b1;
    check_latency(1'b1, "mid_count_release");
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rstn    = 1'b0;
    in      = 1'b0;
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_bouncy_release();
    test_threshold();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
